// File: rtl/jk_excite_driver_if.sv
// Target handshake between the controlling logic and the JK excitation driver.
// The master offers a target value; the slave signals when it can take one.
interface jk_excite_driver_if #(
   parameter int unsigned WIDTH = 4
);
   logic             tgt_valid;
   logic             tgt_ready;
   logic [WIDTH-1:0] tgt_data;

   modport master (output tgt_valid, output tgt_data, input tgt_ready);
   modport slave  (input tgt_valid, input tgt_data, output tgt_ready);
endinterface

// File: rtl/jk_excite_driver.sv
// Drives J/K of a JK flop bank toward a requested target for one clock, then
// verifies the bank landed on it and keeps a saturating mismatch count.
module jk_excite_driver #(
   parameter int unsigned WIDTH     = 4,
   parameter bit          DC_FILL   = 1'b0,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   jk_excite_driver_if.slave    tgt,
   input  logic [WIDTH-1:0]     q_fb,
   output logic [WIDTH-1:0]     j,
   output logic [WIDTH-1:0]     k,
   input  logic                 err_clr,
   output logic                 busy,
   output logic                 done,
   output logic                 mismatch,
   output logic                 last_ok,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam logic [WIDTH-1:0]     DC_VEC  = {WIDTH{DC_FILL}};
   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t                 state, state_nxt;
   logic [WIDTH-1:0]       target, target_nxt;
   logic [WIDTH-1:0]       j_nxt, k_nxt;
   logic                   done_nxt, mismatch_nxt, last_ok_nxt;
   logic [ERR_CNT_W-1:0]   err_nxt;
   logic                   accept_c;
   logic                   diff_c;

   assign tgt.tgt_ready = reset & (state == IDLE);
   assign accept_c      = tgt.tgt_valid & tgt.tgt_ready;
   assign busy          = (state != IDLE);
   assign diff_c        = (q_fb != target);

   // Next-state and next-output decode; everything lands in registers below.
   always_comb begin
      state_nxt    = state;
      target_nxt   = target;
      j_nxt        = '0;
      k_nxt        = '0;
      done_nxt     = 1'b0;
      mismatch_nxt = 1'b0;
      last_ok_nxt  = last_ok;
      err_nxt      = err_count;

      case (state)
         IDLE: begin
            if (accept_c) begin
               state_nxt  = DRIVE;
               target_nxt = tgt.tgt_data;
               // Set where 0->1, reset where 1->0, don't-care terms take DC_FILL.
               j_nxt      = (~q_fb & tgt.tgt_data) | (q_fb & DC_VEC);
               k_nxt      = (q_fb & ~tgt.tgt_data) | (~q_fb & DC_VEC);
            end
         end
         DRIVE: begin
            state_nxt = CHECK;
         end
         CHECK: begin
            state_nxt    = IDLE;
            done_nxt     = 1'b1;
            mismatch_nxt = diff_c;
            last_ok_nxt  = ~diff_c;
            if (diff_c && (err_count != ERR_MAX)) begin
               err_nxt = err_count + ERR_CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (err_clr) begin
         err_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         target    <= '0;
         j         <= '0;
         k         <= '0;
         done      <= 1'b0;
         mismatch  <= 1'b0;
         last_ok   <= 1'b0;
         err_count <= '0;
      end else begin
         state     <= state_nxt;
         target    <= target_nxt;
         j         <= j_nxt;
         k         <= k_nxt;
         done      <= done_nxt;
         mismatch  <= mismatch_nxt;
         last_ok   <= last_ok_nxt;
         err_count <= err_nxt;
      end
   end

endmodule

// File: tb/tb_jk_excite_driver.sv
// Bench for jk_excite_driver: two instances (DC_FILL 0 and 1) each driving a
// 4-bit JK flop bank, checked against a transaction-timed reference model.
module tb_jk_excite_driver;

   localparam int unsigned W     = 4;
   localparam int unsigned ERR_W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         tgt_valid = 1'b0;
   logic [W-1:0] tgt_data = '0;
   logic         err_clr = 1'b0;
   logic         cut = 1'b0;

   logic [W-1:0]     bank0, bank1, fb0;
   logic [W-1:0]     j0, k0, j1, k1;
   logic             busy0, done0, mis0, lok0;
   logic             busy1, done1, mis1, lok1;
   logic [ERR_W-1:0] err0, err1;

   always #5 clk = ~clk;

   jk_excite_driver_if #(.WIDTH(W)) tif0 ();
   jk_excite_driver_if #(.WIDTH(W)) tif1 ();
   assign tif0.tgt_valid = tgt_valid;
   assign tif0.tgt_data  = tgt_data;
   assign tif1.tgt_valid = tgt_valid;
   assign tif1.tgt_data  = tgt_data;

   assign fb0 = cut ? '0 : bank0;

   jk_excite_driver #(.WIDTH(W), .DC_FILL(1'b0), .ERR_CNT_W(ERR_W)) dut0 (
      .clk(clk), .reset(rst_n), .tgt(tif0), .q_fb(fb0), .j(j0), .k(k0),
      .err_clr(err_clr), .busy(busy0), .done(done0), .mismatch(mis0),
      .last_ok(lok0), .err_count(err0));

   jk_excite_driver #(.WIDTH(W), .DC_FILL(1'b1), .ERR_CNT_W(ERR_W)) dut1 (
      .clk(clk), .reset(rst_n), .tgt(tif1), .q_fb(bank1), .j(j1), .k(k1),
      .err_clr(err_clr), .busy(busy1), .done(done1), .mismatch(mis1),
      .last_ok(lok1), .err_count(err1));

   // The two JK flop banks being driven
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank0 <= '0;
         bank1 <= '0;
      end else begin
         bank0 <= (j0 & ~bank0) | (~k0 & bank0);
         bank1 <= (j1 & ~bank1) | (~k1 & bank1);
      end
   end

   int checks = 0;
   int failures = 0;

   // Reference model: timing expressed as edge distance from the last accept
   int         e = 0;
   int         acc_e = -1000;
   logic [W-1:0] m_bank [2];
   logic [W-1:0] m_tgt  [2];
   logic [W-1:0] m_j    [2];
   logic [W-1:0] m_k    [2];
   logic         m_mis  [2];
   logic         m_lok  [2];
   int           m_err  [2];
   logic         m_done, m_busy;

   function automatic logic [2*W-1:0] excite(input logic [W-1:0] cur,
                                             input logic [W-1:0] t,
                                             input logic dc);
      logic [W-1:0] jj, kk;
      for (int b = 0; b < W; b++) begin
         if (!cur[b] && !t[b])      begin jj[b] = 1'b0; kk[b] = dc;   end
         else if (!cur[b] && t[b])  begin jj[b] = 1'b1; kk[b] = dc;   end
         else if (cur[b] && !t[b])  begin jj[b] = dc;   kk[b] = 1'b1; end
         else                       begin jj[b] = dc;   kk[b] = 1'b0; end
      end
      return {jj, kk};
   endfunction

   task automatic model_reset();
      acc_e  = -1000;
      m_done = 1'b0;
      m_busy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_bank[i] = '0; m_tgt[i] = '0; m_j[i] = '0; m_k[i] = '0;
         m_mis[i] = 1'b0; m_lok[i] = 1'b0; m_err[i] = 0;
      end
   endtask

   // Advance model across one rising edge using inputs present before it.
   task automatic model_edge();
      logic [W-1:0] fb [2];
      int d;
      bit acc;
      if (!rst_n) begin
         model_reset();
      end else begin
         fb[0]  = cut ? '0 : m_bank[0];
         fb[1]  = m_bank[1];
         d      = e - acc_e;
         acc    = tgt_valid && (d >= 3);
         m_done = (d == 2);
         m_busy = acc || (d == 1);
         for (int i = 0; i < 2; i++) begin
            m_bank[i] = (m_j[i] & ~m_bank[i]) | (~m_k[i] & m_bank[i]);
            if (m_done) begin
               m_mis[i] = (fb[i] != m_tgt[i]);
               m_lok[i] = (fb[i] == m_tgt[i]);
               if (m_mis[i] && m_err[i] < 255) m_err[i]++;
            end else begin
               m_mis[i] = 1'b0;
            end
            if (err_clr) m_err[i] = 0;
            if (acc) begin
               {m_j[i], m_k[i]} = excite(fb[i], tgt_data, (i == 1));
               m_tgt[i] = tgt_data;
            end else begin
               m_j[i] = '0;
               m_k[i] = '0;
            end
         end
         if (acc) acc_e = e;
      end
      e++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/j0"},     32'(j0),     32'(m_j[0]));
      chk({tag, "/k0"},     32'(k0),     32'(m_k[0]));
      chk({tag, "/j1"},     32'(j1),     32'(m_j[1]));
      chk({tag, "/k1"},     32'(k1),     32'(m_k[1]));
      chk({tag, "/busy0"},  32'(busy0),  32'(m_busy));
      chk({tag, "/busy1"},  32'(busy1),  32'(m_busy));
      chk({tag, "/done0"},  32'(done0),  32'(m_done));
      chk({tag, "/done1"},  32'(done1),  32'(m_done));
      chk({tag, "/mis0"},   32'(mis0),   32'(m_mis[0]));
      chk({tag, "/mis1"},   32'(mis1),   32'(m_mis[1]));
      chk({tag, "/lok0"},   32'(lok0),   32'(m_lok[0]));
      chk({tag, "/lok1"},   32'(lok1),   32'(m_lok[1]));
      chk({tag, "/err0"},   32'(err0),   32'(m_err[0]));
      chk({tag, "/err1"},   32'(err1),   32'(m_err[1]));
      chk({tag, "/ready0"}, 32'(tif0.tgt_ready), 32'(rst_n && !m_busy));
      chk({tag, "/ready1"}, 32'(tif1.tgt_ready), 32'(rst_n && !m_busy));
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   typedef struct {
      logic [W-1:0] data;
      logic         cut;
      logic [W-1:0] j0, k0, j1, k1;
      logic         mis0, mis1;
   } vec_t;

   vec_t vecs [5];
   int   acc_cnt;
   bit   clr_now;

   initial begin
      // Directed transactions from bank=0000; j1/k1 are the DC_FILL=1 excitations
      vecs[0] = '{data: 4'b1010, cut: 1'b0, j0: 4'b1010, k0: 4'b0000, j1: 4'b1010, k1: 4'b1111, mis0: 1'b0, mis1: 1'b0};
      vecs[1] = '{data: 4'b0110, cut: 1'b0, j0: 4'b0100, k0: 4'b1000, j1: 4'b1110, k1: 4'b1101, mis0: 1'b0, mis1: 1'b0};
      vecs[2] = '{data: 4'b0110, cut: 1'b0, j0: 4'b0000, k0: 4'b0000, j1: 4'b0110, k1: 4'b1001, mis0: 1'b0, mis1: 1'b0};
      vecs[3] = '{data: 4'b0001, cut: 1'b0, j0: 4'b0001, k0: 4'b0110, j1: 4'b0111, k1: 4'b1111, mis0: 1'b0, mis1: 1'b0};
      vecs[4] = '{data: 4'b1111, cut: 1'b1, j0: 4'b1111, k0: 4'b0000, j1: 4'b1111, k1: 4'b1110, mis0: 1'b1, mis1: 1'b0};

      model_reset();
      rst_n = 1'b0;

      // Reset held for three clocks
      for (int c = 0; c < 3; c++) step("reset");
      chk("rst_j0", 32'(j0), 32'h0);
      chk("rst_k0", 32'(k0), 32'h0);
      chk("rst_ready0", 32'(tif0.tgt_ready), 32'h0);
      chk("rst_err0", 32'(err0), 32'h0);
      chk("rst_done0", 32'(done0), 32'h0);
      rst_n = 1'b1;
      #1;
      chk("release_ready0", 32'(tif0.tgt_ready), 32'h1);

      // Table-driven directed transactions
      for (int v = 0; v < 5; v++) begin
         tgt_valid = 1'b1;
         tgt_data  = vecs[v].data;
         cut       = vecs[v].cut;
         step("vec_acc");
         chk("vec_j0", 32'(j0), 32'(vecs[v].j0));
         chk("vec_k0", 32'(k0), 32'(vecs[v].k0));
         chk("vec_j1", 32'(j1), 32'(vecs[v].j1));
         chk("vec_k1", 32'(k1), 32'(vecs[v].k1));
         tgt_valid = 1'b0;
         tgt_data  = ~vecs[v].data;
         step("vec_drv");
         step("vec_chk");
         chk("vec_done0", 32'(done0), 32'h1);
         chk("vec_mis0", 32'(mis0), 32'(vecs[v].mis0));
         chk("vec_mis1", 32'(mis1), 32'(vecs[v].mis1));
         chk("vec_lok0", 32'(lok0), 32'(!vecs[v].mis0));
         cut = 1'b0;
      end
      chk("first_err0", 32'(err0), 32'h1);

      // Saturation of the mismatch counter with feedback cut
      cut       = 1'b1;
      tgt_valid = 1'b1;
      tgt_data  = 4'b1111;
      for (int c = 0; c < 900; c++) step("sat");
      chk("sat_err0", 32'(err0), 32'd255);
      chk("sat_err1", 32'(err1), 32'd0);

      // err_clr coinciding with a mismatch edge
      for (int c = 0; c < 3; c++) begin
         clr_now = ((e - acc_e) == 2);
         err_clr = clr_now;
         step("clr");
         err_clr = 1'b0;
         if (clr_now) break;
      end
      chk("clr_done0", 32'(done0), 32'h1);
      chk("clr_mis0", 32'(mis0), 32'h1);
      chk("clr_err0", 32'(err0), 32'h0);
      tgt_valid = 1'b0;
      cut       = 1'b0;
      step("drain");
      step("drain");

      // tgt_valid held high: one accept per three cycles
      acc_cnt = 0;
      tgt_valid = 1'b1;
      for (int c = 0; c < 30; c++) begin
         tgt_data = 4'($urandom);
         if (tif0.tgt_ready) acc_cnt++;
         step("held");
      end
      chk("held_accepts", 32'(acc_cnt), 32'd10);
      tgt_valid = 1'b0;
      step("drain");
      step("drain");

      // Reset asserted mid-DRIVE
      tgt_valid = 1'b1;
      tgt_data  = ~m_bank[0];
      step("rst_acc");
      tgt_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_j0", 32'(j0), 32'h0);
      chk("abort_k0", 32'(k0), 32'h0);
      chk("abort_j1", 32'(j1), 32'h0);
      chk("abort_k1", 32'(k1), 32'h0);
      chk("abort_busy0", 32'(busy0), 32'h0);
      chk("abort_ready0", 32'(tif0.tgt_ready), 32'h0);
      model_reset();
      step("abort_hold");
      step("abort_hold");
      rst_n = 1'b1;
      tgt_valid = 1'b1;
      tgt_data  = 4'b0101;
      step("post_acc");
      tgt_valid = 1'b0;
      step("post_drv");
      step("post_chk");
      chk("post_done0", 32'(done0), 32'h1);
      chk("post_mis0", 32'(mis0), 32'h0);
      chk("post_lok0", 32'(lok0), 32'h1);

      // Randomized traffic against the model
      for (int c = 0; c < 2000; c++) begin
         rst_n     = ($urandom_range(0, 99) != 0);
         tgt_valid = ($urandom_range(0, 3) != 0);
         tgt_data  = 4'($urandom);
         err_clr   = ($urandom_range(0, 15) == 0);
         cut       = ($urandom_range(0, 3) == 0);
         step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
